// File: rtl/sar_pkg.sv
// Shared constants and helpers for the successive-approximation search controller.
package sar_pkg;

  localparam int unsigned SAR_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold a bit index 0..width-1 (at least one bit).
  function automatic int unsigned sar_idx_w(input int unsigned width);
    int unsigned w;
    w = 0;
    while ((1 << w) < width) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller, MSB first, driving an external comparator.
// Optional early exit on an equal compare: define SAR_EARLY_EXIT_EN.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             g_in,
  input  logic             l_in,
  input  logic             e_in,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned    IDX_W = sar_idx_w(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             keep;
  logic             one_hot;
  logic [WIDTH-1:0] acc;

  // Next-state and datapath decisions.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    err_d    = err_q;
    keep     = g_in | e_in;
    one_hot  = ({g_in, l_in, e_in} == 3'b100) || ({g_in, l_in, e_in} == 3'b010) ||
               ({g_in, l_in, e_in} == 3'b001);
    // Current trial already has zeros below idx; only bit idx is decided here.
    acc        = trial_q;
    acc[idx_q] = keep;

    case (state_q)
      ST_IDLE: begin
        trial_d = '0;
        if (start) begin
          trial_d = MSB_ONE;
          idx_d   = IDX_TOP;
          err_d   = 1'b0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (!one_hot) err_d = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
        if (e_in && one_hot) begin
          result_d = trial_q;
          trial_d  = '0;
          idx_d    = IDX_TOP;
          state_d  = ST_DONE;
        end else
`endif
        if (idx_q == '0) begin
          result_d = acc;
          trial_d  = '0;
          idx_d    = IDX_TOP;
          state_d  = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          trial_d = acc | (WIDTH'(1) << (idx_q - IDX_W'(1)));
        end
      end
      ST_DONE: begin
        trial_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        trial_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CMP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= IDX_TOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Closed-loop bench: behavioural comparator plus a binary-search reference model.
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       g_in;
  logic       l_in;
  logic       e_in;
  logic [3:0] trial;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  logic [3:0] tgt;
  logic       bad_now;

  int n_checks;
  int n_pass;

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .g_in   (g_in),
    .l_in   (l_in),
    .e_in   (e_in),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Magnitude comparator; bad_now corrupts the flags to g=l=1.
  always_comb begin
    g_in = bad_now ? 1'b1 : (tgt > trial);
    l_in = bad_now ? 1'b1 : (tgt < trial);
    e_in = bad_now ? 1'b0 : (tgt == trial);
  end

  // Runs one search; bad_idx selects a corrupted compare (-1 for none),
  // noise re-pulses start during a compare and during the done cycle.
  task automatic do_search(input logic [3:0] t, input int bad_idx, input bit noise,
                           input string nm);
    logic [3:0] seq[$];
    logic [3:0] val;
    logic [3:0] tr;
    logic       bad;
    int         n;
    val = 4'd0;
    for (int b = 3; b >= 0; b--) begin
      tr  = val | (4'(1) << b);
      seq.push_back(tr);
      bad = ((seq.size() - 1) == bad_idx);
      if (bad || (t >= tr)) val = tr;
`ifdef SAR_EARLY_EXIT_EN
      if (!bad && (tr == t)) break;
`endif
    end
    n = seq.size();

    @(negedge clk);
    tgt     = t;
    bad_now = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start   = noise && (i == 1);
      bad_now = (i == bad_idx);
      n_checks++;
      if (trial !== seq[i] || busy !== 1'b1 || done !== 1'b0 ||
          err !== ((bad_idx >= 0) && (bad_idx < i)))
        $display("FAIL %s cmp%0d: trial=%0d busy=%b done=%b err=%b, want trial=%0d busy=1 done=0 err=%b",
                 nm, i, trial, busy, done, err, seq[i], (bad_idx >= 0) && (bad_idx < i));
      else n_pass++;
    end

    @(negedge clk);
    bad_now = 1'b0;
    start   = noise;
    n_checks++;
    if (done !== 1'b1 || result !== val || trial !== 4'd0 || busy !== 1'b0 ||
        err !== ((bad_idx >= 0) && (bad_idx < n)))
      $display("FAIL %s done: done=%b result=%0d trial=%0d busy=%b err=%b, want done=1 result=%0d trial=0 busy=0 err=%b",
               nm, done, result, trial, busy, err, val, (bad_idx >= 0) && (bad_idx < n));
    else n_pass++;

    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || trial !== 4'd0 || result !== val)
      $display("FAIL %s post: done=%b busy=%b trial=%0d result=%0d, want 0 0 0 %0d",
               nm, done, busy, trial, result, val);
    else n_pass++;

    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || trial !== 4'd0)
      $display("FAIL %s idle: busy=%b done=%b trial=%0d, want 0 0 0", nm, busy, done, trial);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (trial !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 || err !== 1'b0)
      $display("FAIL reset: trial=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               trial, busy, done, result, err);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_search(4'd11, -1, 1'b0, "tgt11");
    do_search(4'd8,  -1, 1'b0, "tgt8");
    do_search(4'd0,  -1, 1'b0, "tgt0");
    do_search(4'd15, -1, 1'b0, "tgt15");
  endtask

  task automatic test_start_ignored();
    do_search(4'd6, -1, 1'b1, "noise6");
    do_search(4'd13, -1, 1'b1, "noise13");
  endtask

  task automatic test_flag_error();
    do_search(4'd3, 1, 1'b0, "err3");
    do_search(4'd3, -1, 1'b0, "errclr");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tgt     = 4'd5;
    bad_now = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (trial !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 || err !== 1'b0)
      $display("FAIL rst_mid: trial=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               trial, busy, done, result, err);
    else n_pass++;
    rst = 1'b0;
    do_search(4'd13, -1, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [3:0] t;
    int         b;
    for (int k = 0; k < 12; k++) begin
      t = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_search(t, b, 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    tgt      = 4'd0;
    bad_now  = 1'b0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_flag_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
